// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - 7-seg scan bus reader that rebuilds 32-bit frames (option: SEG_DECODE_BLANK_EN)
module seg_scan_decoder #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 500000,
   parameter int STABLE_FRAMES  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  seg_an,
   input  logic [3:0]  seg_data,
   output logic [31:0] frame_data,
   output logic [7:0]  frame_mask,
   output logic        frame_valid,
   output logic        stable,
   output logic        idle
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int MW = $clog2(STABLE_FRAMES + 1);

   localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [MW-1:0] MATCH_MAX    = MW'(STABLE_FRAMES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_LOCKED} state_t;

   state_t        state, state_n;
   logic [2:0]    an_s1, an_s2;
   logic [3:0]    data_s1, data_s2;
   logic [6:0]    s_prev;
   logic          changed;
   logic [SW-1:0] settle_cnt, settle_n;
   logic [TW-1:0] idle_cnt;
   logic [MW-1:0] match_cnt, match_n;
   logic [31:0]   shadow, merged;
   logic [7:0]    seen;
   logic [2:0]    last_idx;
   logic          accept, timeout, wrap, commit, same;

   assign changed = ({an_s2, data_s2} != s_prev);
   assign idle    = (state == ST_IDLE);

   // Two-flop synchroniser on the scan bus plus one delayed copy for change detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_s1   <= '0;
         an_s2   <= '0;
         data_s1 <= '0;
         data_s2 <= '0;
         s_prev  <= '0;
      end else begin
         an_s1   <= seg_an;
         an_s2   <= an_s1;
         data_s1 <= seg_data;
         data_s2 <= data_s1;
         s_prev  <= {an_s2, data_s2};
      end
   end

   // FSM and settle counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
      end else begin
         state      <= state_n;
         settle_cnt <= settle_n;
      end
   end

   // Next state: debounce each {an,data} pair, accept once it has held long enough, drop out on inactivity
   always_comb begin
      state_n  = state;
      settle_n = settle_cnt;
      accept   = 1'b0;
      timeout  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (changed) begin
               state_n  = ST_TRACK;
               settle_n = SW'(1);
            end
         end
         ST_TRACK: begin
            if (changed) begin
               settle_n = SW'(1);
            end else if (settle_cnt >= SETTLE_LAST) begin
               accept   = 1'b1;
               state_n  = ST_LOCKED;
               settle_n = SETTLE_MAX;
            end else begin
               settle_n = settle_cnt + 1'b1;
            end
         end
         ST_LOCKED: begin
            if (changed) begin
               state_n  = ST_TRACK;
               settle_n = SW'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (state != ST_IDLE && !accept && idle_cnt >= TIMEOUT_LAST) begin
         timeout = 1'b1;
         state_n = ST_IDLE;
      end
   end

   // Frame merge and stability match; a lower digit index than the last one marks a new scan pass
   always_comb begin
      merged = '0;
      for (int i = 0; i < 8; i++) begin
`ifdef SEG_DECODE_BLANK_EN
         merged[4*i +: 4] = seen[i] ? shadow[4*i +: 4] : 4'h0;
`else
         merged[4*i +: 4] = seen[i] ? shadow[4*i +: 4] : frame_data[4*i +: 4];
`endif
      end
      wrap    = accept && (an_s2 < last_idx);
      commit  = (wrap || timeout) && (seen != 8'h00);
      same    = (merged == frame_data) && (seen == frame_mask);
      match_n = '0;
      if (same) begin
         match_n = (match_cnt >= MATCH_MAX) ? match_cnt : match_cnt + 1'b1;
      end
   end

   // Shadow buffer, committed frame, stability tracking and inactivity counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_data  <= '0;
         frame_mask  <= '0;
         frame_valid <= 1'b0;
         stable      <= 1'b0;
         shadow      <= '0;
         seen        <= '0;
         last_idx    <= '0;
         idle_cnt    <= '0;
         match_cnt   <= '0;
      end else begin
         frame_valid <= commit;
         if (commit) begin
            frame_data <= merged;
            frame_mask <= seen;
         end
         if (timeout) begin
            match_cnt <= '0;
            stable    <= 1'b0;
            seen      <= '0;
            last_idx  <= '0;
         end else begin
            if (commit) begin
               match_cnt <= match_n;
               stable    <= (match_n == MATCH_MAX);
            end
            if (accept) begin
               shadow[{an_s2, 2'b00} +: 4] <= data_s2;
               last_idx <= an_s2;
               seen     <= wrap ? (8'b1 << an_s2) : (seen | (8'b1 << an_s2));
            end
         end
         if (state == ST_IDLE || accept || timeout) begin
            idle_cnt <= '0;
         end else if (idle_cnt != TIMEOUT_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

endmodule
